id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the RV32IM core. It registers one decoded instruction per cycle and drives the execute-stage ALU operands and operation select (`DATA1`, `DATA2`, `SELECT`). It resolves data hazards in two ways: it forwards results from EX/MEM and MEM/WB into the operands, and it detects load-use hazards, raising a stall and inserting a bubble. A branch flush from EX turns the stage contents into a bubble.

## Interface
- `XLEN`, default 32: datapath width.
- `RA_W`, default 5: register-address width.

- `CLK`  in  1  rising-edge clock.
- `RESET`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  decode slot holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm`  in  XLEN  decode PC, register-file reads, sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd`  in  RA_W  source and destination register numbers.
- `id_alu_select`  in  5  ALU operation code (shared encoding).
- `id_op1_pc`, `id_op2_imm`  in  1  operand-source selects: PC for operand 1, immediate for operand 2.
- `id_reg_write`, `id_mem_read`, `id_mem_write`  in  1  decoded control.
- `flush`  in  1  taken branch/jump resolved in EX.
- `mem_rd`  in  RA_W, `mem_reg_write`  in  1, `mem_result`  in  XLEN  EX/MEM forwarding source.
- `wb_rd`  in  RA_W, `wb_reg_write`  in  1, `wb_data`  in  XLEN  MEM/WB forwarding source.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write`  out  1  registered control.
- `ex_rd`  out  RA_W; `ex_pc`  out  XLEN  registered.
- `DATA1`, `DATA2`  out  XLEN  ALU operands (forwarded, muxed).
- `SELECT`  out  5  ALU operation.
- `ex_store_data`  out  XLEN  forwarded rs2 for stores.

## Operation
- The stage register loads on every rising `CLK`. Priority, highest first:
  - `RESET`: all fields 0.
  - `flush`: bubble.
  - `stall`: bubble.
  - `id_valid=0`: bubble.
  - Otherwise: load the `id_*` fields.
- A bubble has `ex_valid`, `ex_reg_write`, `ex_mem_read` and `ex_mem_write` at 0, `SELECT`=0, and every data/address field at 0.
- `stall` is combinational and equals `id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & (ex_rd==id_rs1 | ex_rd==id_rs2) & ~flush`.
  - Both source registers are always compared, whether or not the instruction uses rs2 (conservative by design).
- Forwarding applies to each stored source register r (rs1, rs2) and is combinational:
  - If `mem_reg_write & mem_rd==r & r!=0`, use `mem_result`.
  - Else if `wb_reg_write & wb_rd==r & r!=0`, use `wb_data`.
  - Else use the stored register-file value.
  - x0 is never forwarded.
- Operand muxing:
  - `DATA1` = `op1_pc` ? `ex_pc` : forwarded rs1.
  - `DATA2` = `op2_imm` ? stored imm : forwarded rs2.
  - `ex_store_data` = forwarded rs2, always.
- `SELECT` passes the registered `id_alu_select` through unchanged; no re-encoding.
- No decode-side bypass. The register file writes before it reads within a cycle; that is a system requirement outside this block.

## Timing
- Latency from `id_*` to `ex_*` is one cycle. Forwarding and `stall` add zero cycles (combinational).
- Reset values: every registered output is 0, and `stall` is 0 because `ex_valid`=0. Reset asserted mid-stall clears the stage on the next edge.
- Stall duration is exactly one cycle per load-use hazard. The following cycle the EX slot holds a bubble, the load has moved to MEM, and the held instruction issues and forwards from `mem_result`.
- `flush` together with a hazard: `stall`=0 and the stage becomes a bubble.
- `flush` together with `RESET`: reset wins; the result is the same all-zero stage.
- `DATA1`/`DATA2` settle within the same cycle as the forwarding inputs change. The ALU's own delay is additive.

## Structure
- Shared package `pipeline_pkg` holds:
  - `XLEN`, `RA_W`, `REG_ZERO`.
  - ALU select constants: `ALU_ADD`=0, `ALU_SLL`=1, `ALU_SLT`=2, `ALU_SLTU`=3, `ALU_XOR`=4, `ALU_SRL`=5, `ALU_OR`=6, `ALU_AND`=7, `ALU_MUL`=8, `ALU_MULH`=9, `ALU_MULHSU`=10, `ALU_MULHU`=11, `ALU_DIV`=12, `ALU_REM`=13, `ALU_REMU`=15.
- One sub-module, `operand_forward`: the 3-way priority forwarding mux, instantiated twice (rs1, rs2).

## Test plan
- Reset: `RESET`=1 for 2 cycles with `id_valid`=1 -> all outputs 0, `stall`=0; first instruction after release appears one cycle later.
- Plain issue: x3=x1+x2 with `id_rs1_data`=5, `id_rs2_data`=7, select 0 -> next cycle `DATA1`=5, `DATA2`=7, `SELECT`=0, `ex_valid`=1, `ex_rd`=3.
- Forward priority: stage rs1=x4, `mem_rd`=4/`mem_result`=0x11, `wb_rd`=4/`wb_data`=0x22 -> `DATA1`=0x11.
  - Drop `mem_reg_write` -> 0x22.
  - Rerun with rs1=x0 and both `*_rd`=0 -> stored value.
- Load-use: EX holds `lw x5`, decode `add x6,x1,x5` -> `stall`=1 one cycle.
  - Next cycle: `ex_valid`=0, `ex_mem_read`=0, `stall`=0.
  - Following cycle: add issues, `DATA2`=`mem_result`.
- Flush with hazard: same load-use setup plus `flush`=1 -> `stall`=0 and a bubble next cycle.
- Operand select: `id_op1_pc`=1, `id_op2_imm`=1, pc=0x100, imm=0xFFFFFFFC, forwarded rs2=0xAB -> `DATA1`=0x100, `DATA2`=0xFFFFFFFC, `ex_store_data`=0xAB.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath widths, the zero register and the
// ALU operation-select encoding used by decode and execute.
package pipeline_pkg;

    localparam int XLEN     = 32;
    localparam int RA_W     = 5;
    localparam int ALU_SEL_W = 5;

    localparam logic [RA_W-1:0] REG_ZERO = '0;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD    = 5'd0;
    localparam logic [ALU_SEL_W-1:0] ALU_SLL    = 5'd1;
    localparam logic [ALU_SEL_W-1:0] ALU_SLT    = 5'd2;
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU   = 5'd3;
    localparam logic [ALU_SEL_W-1:0] ALU_XOR    = 5'd4;
    localparam logic [ALU_SEL_W-1:0] ALU_SRL    = 5'd5;
    localparam logic [ALU_SEL_W-1:0] ALU_OR     = 5'd6;
    localparam logic [ALU_SEL_W-1:0] ALU_AND    = 5'd7;
    localparam logic [ALU_SEL_W-1:0] ALU_MUL    = 5'd8;
    localparam logic [ALU_SEL_W-1:0] ALU_MULH   = 5'd9;
    localparam logic [ALU_SEL_W-1:0] ALU_MULHSU = 5'd10;
    localparam logic [ALU_SEL_W-1:0] ALU_MULHU  = 5'd11;
    localparam logic [ALU_SEL_W-1:0] ALU_DIV    = 5'd12;
    localparam logic [ALU_SEL_W-1:0] ALU_REM    = 5'd13;
    localparam logic [ALU_SEL_W-1:0] ALU_REMU   = 5'd15;

endpackage

// File: rtl/operand_forward.sv
// Three-way priority forwarding mux for one source register:
// EX/MEM result beats MEM/WB data beats the register-file value; x0 never forwards.
module operand_forward
    import pipeline_pkg::*;
#(
    parameter int XLEN = pipeline_pkg::XLEN,
    parameter int RA_W = pipeline_pkg::RA_W
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd_data
);

    logic rs_nonzero;

    always_comb begin
        rs_nonzero = (rs != RA_W'(REG_ZERO));
        fwd_data   = rf_data;
        if (mem_reg_write && (mem_rd == rs) && rs_nonzero) begin
            fwd_data = mem_result;
        end else if (wb_reg_write && (wb_rd == rs) && rs_nonzero) begin
            fwd_data = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding and load-use stall detection.
// Feeds the execute-stage ALU operands (DATA1/DATA2) and operation select.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN = pipeline_pkg::XLEN,
    parameter int RA_W = pipeline_pkg::RA_W
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 id_valid,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [RA_W-1:0]      id_rs1,
    input  logic [RA_W-1:0]      id_rs2,
    input  logic [RA_W-1:0]      id_rd,
    input  logic [ALU_SEL_W-1:0] id_alu_select,
    input  logic                 id_op1_pc,
    input  logic                 id_op2_imm,
    input  logic                 id_reg_write,
    input  logic                 id_mem_read,
    input  logic                 id_mem_write,
    input  logic                 flush,
    input  logic [RA_W-1:0]      mem_rd,
    input  logic                 mem_reg_write,
    input  logic [XLEN-1:0]      mem_result,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic                 wb_reg_write,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 stall,
    output logic                 ex_valid,
    output logic                 ex_reg_write,
    output logic                 ex_mem_read,
    output logic                 ex_mem_write,
    output logic [RA_W-1:0]      ex_rd,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      DATA1,
    output logic [XLEN-1:0]      DATA2,
    output logic [ALU_SEL_W-1:0] SELECT,
    output logic [XLEN-1:0]      ex_store_data
);

    logic                 valid_q, valid_d;
    logic                 reg_write_q, reg_write_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic                 op1_pc_q, op1_pc_d;
    logic                 op2_imm_q, op2_imm_d;
    logic [RA_W-1:0]      rd_q, rd_d;
    logic [RA_W-1:0]      rs1_q, rs1_d;
    logic [RA_W-1:0]      rs2_q, rs2_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [XLEN-1:0]      rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]      rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]      imm_q, imm_d;
    logic [ALU_SEL_W-1:0] sel_q, sel_d;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    logic            load_use;

    // Both sources are compared even when rs2 is unused: a spare stall is
    // cheaper than decoding operand usage here. A flush kills the stall.
    always_comb begin
        load_use = valid_q && mem_read_q && (rd_q != RA_W'(REG_ZERO)) &&
                   ((rd_q == id_rs1) || (rd_q == id_rs2));
        stall    = id_valid && load_use && !flush;
    end

    always_comb begin
        valid_d     = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        op1_pc_d    = 1'b0;
        op2_imm_d   = 1'b0;
        rd_d        = '0;
        rs1_d       = '0;
        rs2_d       = '0;
        pc_d        = '0;
        rs1_data_d  = '0;
        rs2_data_d  = '0;
        imm_d       = '0;
        sel_d       = '0;
        if (!flush && !stall && id_valid) begin
            valid_d     = 1'b1;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
            mem_write_d = id_mem_write;
            op1_pc_d    = id_op1_pc;
            op2_imm_d   = id_op2_imm;
            rd_d        = id_rd;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            pc_d        = id_pc;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            sel_d       = id_alu_select;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            op1_pc_q    <= 1'b0;
            op2_imm_q   <= 1'b0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            sel_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            op1_pc_q    <= op1_pc_d;
            op2_imm_q   <= op2_imm_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            sel_q       <= sel_d;
        end
    end

    operand_forward #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs            (rs1_q),
        .rf_data       (rs1_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs1)
    );

    operand_forward #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs            (rs2_q),
        .rf_data       (rs2_data_q),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_data       (wb_data),
        .fwd_data      (fwd_rs2)
    );

    always_comb begin
        ex_valid      = valid_q;
        ex_reg_write  = reg_write_q;
        ex_mem_read   = mem_read_q;
        ex_mem_write  = mem_write_q;
        ex_rd         = rd_q;
        ex_pc         = pc_q;
        SELECT        = sel_q;
        DATA1         = op1_pc_q  ? pc_q  : fwd_rs1;
        DATA2         = op2_imm_q ? imm_q : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a transaction-level model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_id_ex_stage;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_select;
    logic        id_op1_pc, id_op2_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        flush;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_data;
    logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd, SELECT;
    logic [31:0] ex_pc, DATA1, DATA2, ex_store_data;

    int total = 0;
    int bad   = 0;
    bit started = 0;

    id_ex_stage dut (
        .CLK(CLK), .RESET(RESET), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_alu_select(id_alu_select), .id_op1_pc(id_op1_pc),
        .id_op2_imm(id_op2_imm), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .flush(flush),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .stall(stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_rd(ex_rd),
        .ex_pc(ex_pc), .DATA1(DATA1), .DATA2(DATA2), .SELECT(SELECT),
        .ex_store_data(ex_store_data)
    );

    always #5 CLK = ~CLK;

    // Instruction as seen by the execute stage; an empty slot is all zeros.
    typedef struct {
        bit          valid, reg_write, mem_read, mem_write, op1_pc, op2_imm;
        logic [4:0]  rd, rs1, rs2, sel;
        logic [31:0] pc, rs1_val, rs2_val, imm;
    } instr_t;

    instr_t slot;

    function automatic instr_t empty_slot();
        instr_t e;
        e.valid = 0; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
        e.op1_pc = 0; e.op2_imm = 0;
        e.rd = 0; e.rs1 = 0; e.rs2 = 0; e.sel = 0;
        e.pc = 0; e.rs1_val = 0; e.rs2_val = 0; e.imm = 0;
        return e;
    endfunction

    function automatic bit model_hazard();
        return id_valid && slot.valid && slot.mem_read && slot.rd != 0 &&
               (slot.rd == id_rs1 || slot.rd == id_rs2) && !flush;
    endfunction

    // Youngest in-flight producer wins; x0 is hardwired.
    function automatic logic [31:0] latest_value(logic [4:0] r, logic [31:0] rf);
        if (r == 0) return rf;
        if (mem_reg_write && mem_rd == r) return mem_result;
        if (wb_reg_write && wb_rd == r) return wb_data;
        return rf;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        bit hz;
        hz = model_hazard();
        if (RESET || flush || hz || !id_valid) begin
            slot = empty_slot();
        end else begin
            slot.valid = 1; slot.reg_write = id_reg_write;
            slot.mem_read = id_mem_read; slot.mem_write = id_mem_write;
            slot.op1_pc = id_op1_pc; slot.op2_imm = id_op2_imm;
            slot.rd = id_rd; slot.rs1 = id_rs1; slot.rs2 = id_rs2;
            slot.sel = id_alu_select; slot.pc = id_pc;
            slot.rs1_val = id_rs1_data; slot.rs2_val = id_rs2_data;
            slot.imm = id_imm;
        end
        started = 1;
    end

    always @(negedge CLK) begin
        if (started) begin
            logic [31:0] a, b;
            a = latest_value(slot.rs1, slot.rs1_val);
            b = latest_value(slot.rs2, slot.rs2_val);
            chk("m_stall", 32'(stall), 32'(model_hazard()));
            chk("m_valid", 32'(ex_valid), 32'(slot.valid));
            chk("m_regwr", 32'(ex_reg_write), 32'(slot.reg_write));
            chk("m_memrd", 32'(ex_mem_read), 32'(slot.mem_read));
            chk("m_memwr", 32'(ex_mem_write), 32'(slot.mem_write));
            chk("m_rd", 32'(ex_rd), 32'(slot.rd));
            chk("m_pc", ex_pc, slot.pc);
            chk("m_select", 32'(SELECT), 32'(slot.sel));
            chk("m_data1", DATA1, slot.op1_pc ? slot.pc : a);
            chk("m_data2", DATA2, slot.op2_imm ? slot.imm : b);
            chk("m_store", ex_store_data, b);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_select = 0;
        id_op1_pc = 0; id_op2_imm = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0;
    endtask

    task automatic clear_fwd();
        mem_rd = 0; mem_reg_write = 0; mem_result = 0;
        wb_rd = 0; wb_reg_write = 0; wb_data = 0;
    endtask

    task automatic drive_alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                             logic [31:0] d1, logic [31:0] d2, logic [4:0] sel);
        idle_id();
        id_valid = 1; id_pc = 32'h200; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_rs1_data = d1; id_rs2_data = d2; id_alu_select = sel; id_reg_write = 1;
    endtask

    task automatic drive_lw(logic [4:0] rd);
        idle_id();
        id_valid = 1; id_pc = 32'h300; id_rd = rd; id_rs1 = 1; id_rs1_data = 32'h1000;
        id_imm = 4; id_op2_imm = 1; id_mem_read = 1; id_reg_write = 1;
    endtask

    initial begin
        RESET = 1; flush = 0;
        clear_fwd();
        drive_alu(5'd9, 5'd1, 5'd2, 32'h9, 32'h8, 5'd6);
        id_pc = 32'h40;
        step(); step();
        @(negedge CLK);
        chk("rst_valid", 32'(ex_valid), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_data1", DATA1, 0);
        chk("rst_pc", ex_pc, 0);
        @(posedge CLK); #1;
        RESET = 0;
        step();
        @(negedge CLK);
        chk("first_valid", 32'(ex_valid), 1);
        chk("first_pc", ex_pc, 32'h40);
        chk("first_select", 32'(SELECT), 6);

        // Plain issue: add x3, x1, x2
        @(posedge CLK); #1;
        drive_alu(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, 5'd0);
        step();
        idle_id();
        @(negedge CLK);
        chk("add_data1", DATA1, 5);
        chk("add_data2", DATA2, 7);
        chk("add_select", 32'(SELECT), 0);
        chk("add_valid", 32'(ex_valid), 1);
        chk("add_rd", 32'(ex_rd), 3);

        // Forwarding priority on rs1 = x4
        @(posedge CLK); #1;
        drive_alu(5'd7, 5'd4, 5'd0, 32'h99, 32'h0, 5'd0);
        step();
        idle_id();
        mem_rd = 4; mem_reg_write = 1; mem_result = 32'h11;
        wb_rd = 4; wb_reg_write = 1; wb_data = 32'h22;
        @(negedge CLK);
        chk("fwd_mem", DATA1, 32'h11);
        #1 mem_reg_write = 0;
        #1 chk("fwd_wb", DATA1, 32'h22);
        @(posedge CLK); #1;
        drive_alu(5'd7, 5'd0, 5'd0, 32'h33, 32'h0, 5'd0);
        mem_rd = 0; mem_reg_write = 1; wb_rd = 0; wb_reg_write = 1;
        step();
        idle_id();
        @(negedge CLK);
        chk("fwd_x0", DATA1, 32'h33);

        // Load-use: lw x5 then add x6, x1, x5
        @(posedge CLK); #1;
        clear_fwd();
        drive_lw(5'd5);
        step();
        drive_alu(5'd6, 5'd1, 5'd5, 32'h1, 32'h55, 5'd0);
        @(negedge CLK);
        chk("lu_stall", 32'(stall), 1);
        step();
        @(negedge CLK);
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_memrd", 32'(ex_mem_read), 0);
        chk("lu_bubble_stall", 32'(stall), 0);
        @(posedge CLK); #1;
        mem_rd = 5; mem_reg_write = 1; mem_result = 32'h77;
        idle_id();
        @(negedge CLK);
        chk("lu_issue_rd", 32'(ex_rd), 6);
        chk("lu_issue_data2", DATA2, 32'h77);

        // Flush together with a load-use hazard
        @(posedge CLK); #1;
        clear_fwd();
        drive_lw(5'd5);
        step();
        drive_alu(5'd6, 5'd1, 5'd5, 32'h1, 32'h55, 5'd0);
        flush = 1;
        @(negedge CLK);
        chk("fl_stall", 32'(stall), 0);
        step();
        flush = 0;
        idle_id();
        @(negedge CLK);
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_regwr", 32'(ex_reg_write), 0);

        // Operand select: PC and immediate, store data still forwarded
        @(posedge CLK); #1;
        drive_alu(5'd0, 5'd1, 5'd2, 32'h0, 32'h12, 5'd0);
        id_pc = 32'h100; id_imm = 32'hFFFF_FFFC; id_op1_pc = 1; id_op2_imm = 1;
        id_reg_write = 0; id_mem_write = 1;
        wb_rd = 2; wb_reg_write = 1; wb_data = 32'hAB;
        step();
        idle_id();
        @(negedge CLK);
        chk("sel_data1", DATA1, 32'h100);
        chk("sel_data2", DATA2, 32'hFFFF_FFFC);
        chk("sel_store", ex_store_data, 32'hAB);
        chk("sel_memwr", 32'(ex_mem_write), 1);

        // Reset asserted while a stall is pending
        @(posedge CLK); #1;
        clear_fwd();
        drive_lw(5'd5);
        step();
        drive_alu(5'd6, 5'd5, 5'd2, 32'h1, 32'h2, 5'd0);
        RESET = 1;
        step();
        RESET = 0;
        idle_id();
        @(negedge CLK);
        chk("rst_stall_valid", 32'(ex_valid), 0);
        chk("rst_stall_memrd", 32'(ex_mem_read), 0);
        chk("rst_stall_rd", 32'(ex_rd), 0);

        step(); step();
        @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
